// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: carry-select adder split into WIDTH/BLOCK pipeline
// stages with a valid/ready handshake and a single global advance enable.
// Optional feature: define ADDER_SUB_EN to add the 'sub' input (a - b).
module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSTG = WIDTH / BLOCK;

  logic             adv;
  logic [WIDTH-1:0] b_ent;
  logic             c_ent;

  // Registered stage state (_q) and its next value (_d).
  logic [NSTG-1:0]            vld_q, vld_d, c_q, c_d, asg_q, asg_d, bsg_q, bsg_d;
  logic [NSTG-1:0][WIDTH-1:0] s_q, s_d, opa_q, opa_d, opb_q, opb_d;

  // What each stage sees at its input: the ports for stage 0, else the
  // register of the stage before it.
  logic [NSTG-1:0]            vld_x, c_x, asg_x, bsg_x;
  logic [NSTG-1:0][WIDTH-1:0] s_x, opa_x, opb_x;

  logic [BLOCK:0] r0, r1, rsel;

  // The last stage's operand remainder is fully consumed; sink it.
  logic unused_tail;
  assign unused_tail = ^{opa_q[NSTG-1], opb_q[NSTG-1]};

  // The whole pipe moves together whenever the output slot is free or drained.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Effective second operand and carry-in; subtraction is a + ~b + 1.
  always_comb begin
`ifdef ADDER_SUB_EN
    b_ent = sub ? ~b : b;
    c_ent = sub ? 1'b1 : cin;
`else
    b_ent = b;
    c_ent = cin;
`endif
  end

  // Route each stage's inputs: beat entry for stage 0, previous stage otherwise.
  always_comb begin
    vld_x    = '0;
    c_x      = '0;
    asg_x    = '0;
    bsg_x    = '0;
    s_x      = '0;
    opa_x    = '0;
    opb_x    = '0;
    vld_x[0] = in_valid;
    c_x[0]   = c_ent;
    asg_x[0] = a[WIDTH-1];
    bsg_x[0] = b_ent[WIDTH-1];
    opa_x[0] = a;
    opb_x[0] = b_ent;
    for (int k = 1; k < NSTG; k++) begin
      vld_x[k] = vld_q[k-1];
      c_x[k]   = c_q[k-1];
      asg_x[k] = asg_q[k-1];
      bsg_x[k] = bsg_q[k-1];
      s_x[k]   = s_q[k-1];
      opa_x[k] = opa_q[k-1];
      opb_x[k] = opb_q[k-1];
    end
  end

  // Per-stage carry-select: both block sums are formed up front and the
  // carry from the previous stage picks one. Operands are shifted right by
  // one block per stage so every stage works on the low BLOCK bits.
  always_comb begin
    vld_d = vld_x;
    asg_d = asg_x;
    bsg_d = bsg_x;
    s_d   = s_x;
    c_d   = '0;
    opa_d = '0;
    opb_d = '0;
    r0    = '0;
    r1    = '0;
    rsel  = '0;
    for (int k = 0; k < NSTG; k++) begin
      r0   = {1'b0, opa_x[k][BLOCK-1:0]} + {1'b0, opb_x[k][BLOCK-1:0]};
      r1   = {1'b0, opa_x[k][BLOCK-1:0]} + {1'b0, opb_x[k][BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
      rsel = c_x[k] ? r1 : r0;
      s_d[k][k*BLOCK +: BLOCK] = rsel[BLOCK-1:0];
      c_d[k]   = rsel[BLOCK];
      opa_d[k] = opa_x[k] >> BLOCK;
      opb_d[k] = opb_x[k] >> BLOCK;
    end
  end

  // ---- stage boundary: valid, carry, partial sum and sign bits ----
  // Cleared asynchronously so outputs read zero in reset; frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      asg_q <= '0;
      bsg_q <= '0;
      s_q   <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      asg_q <= asg_d;
      bsg_q <= bsg_d;
      s_q   <= s_d;
    end
  end

  // ---- stage boundary: unconsumed operand bits (never observed directly) ----
  // Operand remainders need no reset since the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign sum       = s_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign overflow  = (asg_q[NSTG-1] == bsg_q[NSTG-1]) &
                     (s_q[NSTG-1][WIDTH-1] != asg_q[NSTG-1]);

endmodule

// File: doc/pipelined_csel_adder.md
PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/sum width in bits.
REQ-002 The module SHALL have parameter BLOCK, default 8, giving the carry-select block width; WIDTH SHALL be a multiple of BLOCK, and NSTG = WIDTH/BLOCK.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, operand beat offered.
REQ-006 Port in_ready, output, 1, operand beat accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 Port a, input, WIDTH, first operand.
REQ-008 Port b, input, WIDTH, second operand.
REQ-009 Port cin, input, 1, carry-in.
REQ-010 Port out_valid, output, 1, result beat present.
REQ-011 Port out_ready, input, 1, downstream accepts the result.
REQ-012 Port sum, output, WIDTH, result.
REQ-013 Port cout, output, 1, carry out of bit WIDTH-1.
REQ-014 Port overflow, output, 1, two's-complement signed overflow.

Function
REQ-015 Stage k (0..NSTG-1) SHALL compute block k, bits [k*BLOCK+BLOCK-1 : k*BLOCK], as two ripple sums, one with carry-in 0 and one with carry-in 1, and SHALL select between them with the carry registered from stage k-1 (stage 0 uses cin).
REQ-016 Each stage SHALL register its selected block sum, its block carry-out, the already-computed lower sum bits, and the unconsumed upper operand bits together with a valid bit.
REQ-017 Latency SHALL be exactly NSTG cycles from an accepted beat to out_valid for that beat when out_ready stays high.
REQ-018 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-019 Global advance enable adv = out_ready OR NOT out_valid; in_ready SHALL equal adv combinationally.
REQ-020 When adv is low, every stage register, including the valid bits, SHALL hold its value; sum, cout, overflow and out_valid SHALL stay stable while out_valid is high and out_ready is low.
REQ-021 When adv is high, the valid bits SHALL shift by one stage, and a bubble (in_valid low) SHALL enter stage 0 with valid 0.
REQ-022 sum/cout SHALL equal (a + b' + c') mod 2^(WIDTH+1) of the originating beat, where b' = b and c' = cin unless REQ-032 applies.
REQ-023 overflow SHALL be 1 iff a[WIDTH-1] == b'[WIDTH-1] and sum[WIDTH-1] != a[WIDTH-1].
REQ-024 Results SHALL leave in acceptance order; no beat SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 Simultaneous output pop and input push in the same cycle SHALL both take effect.

Reset
REQ-026 While rst_n is low, all valid bits SHALL be 0, and out_valid, sum, cout and overflow SHALL be 0, independent of clk.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight beats; the first accepted beat after release SHALL appear exactly NSTG cycles later.
REQ-028 in_ready SHALL be 1 during and immediately after reset, because out_valid is 0.

Configuration
REQ-029 Macro ADDER_SUB_EN SHALL control subtraction support.
REQ-030 With ADDER_SUB_EN defined, input port sub (1 bit) SHALL exist and SHALL be captured with its beat.
REQ-031 Without ADDER_SUB_EN, port sub SHALL be absent and the behaviour SHALL be pure addition.
REQ-032 With ADDER_SUB_EN and sub = 1, b' = ~b and c' = 1, so cin is ignored and sum = a - b; cout = 1 means no borrow.

Verification
REQ-033 WIDTH=32, BLOCK=8, a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> after 4 cycles: sum=0x00000000, cout=1, overflow=0.
REQ-034 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
REQ-035 Stream 100 random beats back-to-back while out_ready toggles randomly -> all 100 results match the reference model in order; outputs stay stable while stalled.
REQ-036 Push 3 beats, then assert rst_n=0 for 1 cycle -> out_valid=0 immediately; after release, no stale result appears, and a new beat 0x5+0x3 gives sum=0x8 after 4 cycles.
REQ-037 ADDER_SUB_EN: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0.
REQ-038 WIDTH=16, BLOCK=4, a=0x00FF, b=0x0001, cin=1 -> sum=0x0101 after 4 cycles.
